// File: rtl/genius_pkg.sv
// Shared types and constants for the Genius game datapath.
package genius_pkg;

   localparam int NUM_COLORS = 4;

   typedef logic [1:0] color_code_t;

   typedef enum logic [1:0] {
      ST_IDLE        = 2'd0,
      ST_DEB_PRESS   = 2'd1,
      ST_PRESSED     = 2'd2,
      ST_DEB_RELEASE = 2'd3
   } btn_state_e;

endpackage

// File: rtl/sync_vec.sv
// Vector synchroniser: STAGES flip-flops per bit, each bit treated independently.
module sync_vec #(
   parameter int WIDTH  = 4,
   parameter int STAGES = 2
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [WIDTH-1:0] d_in,
   output logic [WIDTH-1:0] q_out
);

   logic [WIDTH-1:0] chain_q [STAGES];
   logic [WIDTH-1:0] chain_d [STAGES];

   always_comb begin
      chain_d[0] = d_in;
      for (int i = 1; i < STAGES; i++) begin
         chain_d[i] = chain_q[i-1];
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < STAGES; i++) begin
            chain_q[i] <= '0;
         end
      end else begin
         for (int i = 0; i < STAGES; i++) begin
            chain_q[i] <= chain_d[i];
         end
      end
   end

   assign q_out = chain_q[STAGES-1];

endmodule

// File: rtl/button_debounce.sv
// Colour push-button front end: synchronise, debounce, single-press check, encode.
//
//   state          | meaning
//   ---------------+-----------------------------------------------------------
//   ST_IDLE        | no button pattern under test; waits for non-zero + enable
//   ST_DEB_PRESS   | candidate pattern must stay stable for DEBOUNCE_CYCLES
//   ST_PRESSED     | single press accepted; waits for all buttons released
//   ST_DEB_RELEASE | all-zero must stay stable for DEBOUNCE_CYCLES
module button_debounce
   import genius_pkg::*;
#(
   parameter int NUM_BTN         = NUM_COLORS,
   parameter int DEBOUNCE_CYCLES = 50000,
   parameter int SYNC_STAGES     = 2
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic [NUM_BTN-1:0]         btn_raw,
   input  logic                       enable,
   output logic                       press_valid,
   output logic [$clog2(NUM_BTN)-1:0] press_code,
   output logic [NUM_BTN-1:0]         press_onehot,
   output logic                       held,
   output logic                       multi_err
);

   localparam int CODE_W = $clog2(NUM_BTN);
   localparam int CNT_W  = $clog2(DEBOUNCE_CYCLES);
   localparam logic [CNT_W-1:0]   CNT_LOAD = CNT_W'(DEBOUNCE_CYCLES - 1);
   localparam logic [NUM_BTN-1:0] BTN_ONE  = NUM_BTN'(1);

   logic [NUM_BTN-1:0] btn_s;

   btn_state_e         state_q, state_d;
   logic [NUM_BTN-1:0] cand_q, cand_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic               valid_q, valid_d;
   logic               pv_q, pv_d;
   logic               err_q, err_d;
   logic [CODE_W-1:0]  code_q, code_d;
   logic [NUM_BTN-1:0] onehot_q, onehot_d;

   logic               cand_is_onehot;
   logic [CODE_W-1:0]  cand_idx;

   sync_vec #(
      .WIDTH  (NUM_BTN),
      .STAGES (SYNC_STAGES)
   ) u_sync (
      .clk   (clk),
      .rst_n (rst_n),
      .d_in  (btn_raw),
      .q_out (btn_s)
   );

   assign cand_is_onehot = (cand_q != '0) && ((cand_q & (cand_q - BTN_ONE)) == '0);

   // OR of set-bit indices; only meaningful when cand_q is one-hot
   always_comb begin
      cand_idx = '0;
      for (int i = 0; i < NUM_BTN; i++) begin
         if (cand_q[i]) cand_idx = cand_idx | CODE_W'(i);
      end
   end

   always_comb begin
      state_d  = state_q;
      cand_d   = cand_q;
      cnt_d    = cnt_q;
      valid_d  = valid_q;
      code_d   = code_q;
      onehot_d = onehot_q;
      pv_d     = 1'b0;
      err_d    = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (btn_s != '0 && enable) begin
               cand_d  = btn_s;
               cnt_d   = CNT_LOAD;
               state_d = ST_DEB_PRESS;
            end
         end
         ST_DEB_PRESS: begin
            if (btn_s != cand_q || !enable) begin
               state_d = ST_IDLE;
            end else if (cnt_q == '0) begin
               if (cand_is_onehot) begin
                  pv_d     = 1'b1;
                  code_d   = cand_idx;
                  onehot_d = cand_q;
                  valid_d  = 1'b1;
                  state_d  = ST_PRESSED;
               end else begin
                  err_d   = 1'b1;
                  valid_d = 1'b0;
                  cnt_d   = CNT_LOAD;
                  state_d = ST_DEB_RELEASE;
               end
            end else begin
               cnt_d = cnt_q - CNT_W'(1);
            end
         end
         ST_PRESSED: begin
            if (btn_s == '0) begin
               cnt_d   = CNT_LOAD;
               state_d = ST_DEB_RELEASE;
            end
         end
         ST_DEB_RELEASE: begin
            if (btn_s != '0) begin
               cnt_d = CNT_LOAD;
            end else if (cnt_q == '0) begin
               onehot_d = '0;
               valid_d  = 1'b0;
               state_d  = ST_IDLE;
            end else begin
               cnt_d = cnt_q - CNT_W'(1);
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= ST_IDLE;
         cand_q   <= '0;
         cnt_q    <= '0;
         valid_q  <= 1'b0;
         pv_q     <= 1'b0;
         err_q    <= 1'b0;
         code_q   <= '0;
         onehot_q <= '0;
      end else begin
         state_q  <= state_d;
         cand_q   <= cand_d;
         cnt_q    <= cnt_d;
         valid_q  <= valid_d;
         pv_q     <= pv_d;
         err_q    <= err_d;
         code_q   <= code_d;
         onehot_q <= onehot_d;
      end
   end

   // valid_press is only ever set together with entry to PRESSED, so it doubles as held
   assign press_valid  = pv_q;
   assign multi_err    = err_q;
   assign press_code   = code_q;
   assign press_onehot = onehot_q;
   assign held         = valid_q;

endmodule
